// File: rtl/spike_aer_encoder.sv
// Serialises per-neuron spikes into a round-robin AER event stream, with an optional timestamp (SPIKE_AER_TIMESTAMP_EN).
// Latency: 2 edges from spike sample to head of an empty FIFO (pend set, then grant/push).
// Backpressure: ev_ready low holds the head; a full FIFO stalls grants and re-fired pending neurons count as drops.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 4,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_NEURONS-1:0]          spike_in,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [ADDR_W-1:0]             ev_addr,
    output logic [TS_W-1:0]               ev_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
`ifdef SPIKE_AER_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } ev_t;

    logic [N_NEURONS-1:0] pend;
    logic [ADDR_W-1:0]    last_grant;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [7:0]           drops;
    ev_t                  mem [FIFO_DEPTH];
`ifdef SPIKE_AER_TIMESTAMP_EN
    logic [TS_W-1:0]      ts_cnt;
`endif

    logic                 can_push;
    logic                 gnt_vld;
    logic [ADDR_W-1:0]    gnt_idx;
    logic [N_NEURONS-1:0] gnt_onehot;
    logic [N_NEURONS-1:0] merged;
    logic [8:0]           merged_cnt;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_next;
    logic                 push;
    logic                 pop;
    ev_t                  wr_dat;
    ev_t                  head;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign can_push = (count != CNT_W'(FIFO_DEPTH));

    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_NEURONS; k++) begin
            c = (int'(last_grant) + k) % N_NEURONS;
            if (!gnt_vld && can_push && pend[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = ADDR_W'(c);
            end
        end
    end

    assign gnt_onehot = gnt_vld ? (N_NEURONS'(1) << gnt_idx) : '0;
    assign merged     = spike_in & pend & ~gnt_onehot;

    always_comb begin
        merged_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            merged_cnt = merged_cnt + 9'(merged[i]);
        end
    end

    assign drop_sum  = {1'b0, drops} + merged_cnt;
    assign drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

    assign push = gnt_vld;
    assign pop  = (count != '0) && ev_ready;

    always_comb begin
        wr_dat      = '0;
        wr_dat.addr = gnt_idx;
`ifdef SPIKE_AER_TIMESTAMP_EN
        wr_dat.ts   = ts_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            last_grant <= ADDR_W'(N_NEURONS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drops      <= '0;
        end else begin
            // A granted neuron that fires again in the same cycle stays pending as a fresh event.
            pend  <= (pend & ~gnt_onehot) | spike_in;
            drops <= drop_next;
            if (gnt_vld) last_grant <= gnt_idx;
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SPIKE_AER_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign head       = mem[rd_ptr];
    assign ev_valid   = !reset && (count != '0);
    assign ev_addr    = ev_valid ? head.addr : '0;
`ifdef SPIKE_AER_TIMESTAMP_EN
    assign ev_ts      = ev_valid ? head.ts : '0;
`else
    assign ev_ts      = '0;
`endif
    assign fifo_count = reset ? '0 : count;
    assign drop_count = reset ? '0 : drops;

endmodule
